// File: rtl/accumulator_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator processor.
// Drives PC/IR/ACC enables, ALU select and memory strobes. A wait counter
// bounds every memory handshake and forces FAULT when it runs out.
//
// Handshake: a memory strobe (mem_read or mem_write) is held high until the
// cycle in which mem_ready=1. That cycle completes the transfer, and the
// accompanying load pulses appear in the same cycle. If mem_ready is still 0
// when wait_cnt equals MEM_TIMEOUT, the FSM moves to FAULT. A mem_ready in
// that last cycle still counts as a completed transfer.
module accumulator_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int OPERAND_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [OPCODE_W+OPERAND_W-1:0] instr,
    input  logic                          acc_zero,
    input  logic                          acc_neg,
    input  logic                          mem_ready,
    output logic                          pc_inc,
    output logic                          pc_load,
    output logic                          ir_load,
    output logic                          acc_load,
    output logic                          acc_src,
    output logic [1:0]                    alu_op,
    output logic                          addr_sel,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic                          halted,
    output logic                          fault,
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JN    = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_HLT   = OPCODE_W'(15);

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_wait_cnt;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [OPCODE_W-1:0]   w_opcode;
    logic                  w_timeout;
    logic                  w_unused;

    // The operand field is routed to PC/address muxes in the datapath, not here.
    assign w_unused  = &{1'b0, instr[OPERAND_W-1:0]};
    assign w_opcode  = instr[OPCODE_W+OPERAND_W-1:OPERAND_W];
    assign w_timeout = (r_wait_cnt == 8'(MEM_TIMEOUT));
    assign state_dbg = r_state;

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Keep the decoded opcode so MEM/EXEC do not depend on instr after DECODE.
    always_ff @(posedge clock) begin
        if (reset)                  r_opcode <= OP_NOP;
        else if (r_state == S_DECODE) r_opcode <= w_opcode;
    end

    // Wait counter: cleared on any state change, counts stalled handshake cycles.
    always_ff @(posedge clock) begin
        if (reset)
            r_wait_cnt <= 8'd0;
        else if (w_next != r_state)
            r_wait_cnt <= 8'd0;
        else if (!mem_ready && (r_state == S_FETCH || r_state == S_MEM))
            r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    // Next-state and output decode from the current state (plus mem_ready).
    always_comb begin
        w_next    = r_state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        acc_load  = 1'b0;
        acc_src   = 1'b0;
        alu_op    = 2'b00;
        addr_sel  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_NOP:                  w_next = S_FETCH;
                    OP_LOAD, OP_STORE,
                    OP_ADD, OP_SUB, OP_AND:  w_next = S_MEM;
                    OP_JMP, OP_JZ, OP_JN:    w_next = S_EXEC;
                    OP_HLT:                  w_next = S_HALT;
                    default:                 w_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (r_opcode == OP_STORE) mem_write = 1'b1;
                else                      mem_read  = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                    if (r_opcode != OP_STORE) acc_load = 1'b1;
                    case (r_opcode)
                        OP_ADD: begin acc_src = 1'b1; alu_op = 2'b00; end
                        OP_SUB: begin acc_src = 1'b1; alu_op = 2'b01; end
                        OP_AND: begin acc_src = 1'b1; alu_op = 2'b10; end
                        default: ;
                    endcase
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (r_opcode)
                    OP_JMP:  pc_load = 1'b1;
                    OP_JZ:   pc_load = acc_zero;
                    OP_JN:   pc_load = acc_neg;
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Bench for accumulator_control_unit: instruction-level reference model that
// expands each instruction into its expected per-cycle output sequence.
module tb_accumulator_control_unit;

    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_inc, pc_load, ir_load, acc_load, acc_src;
    logic [1:0] alu_op;
    logic       addr_sel, mem_read, mem_write, halted, fault;
    logic [2:0] state_dbg;

    accumulator_control_unit #(
        .OPCODE_W(4), .OPERAND_W(4), .MEM_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .instr(instr),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ready(mem_ready),
        .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
        .acc_load(acc_load), .acc_src(acc_src), .alu_op(alu_op),
        .addr_sel(addr_sel), .mem_read(mem_read), .mem_write(mem_write),
        .halted(halted), .fault(fault), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clock = ~clock;

    localparam logic [11:0] ZERO = 12'b0;

    logic [11:0] exp_q[$];
    logic [11:0] act;
    logic [11:0] e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    assign act = {pc_inc, pc_load, ir_load, acc_load, acc_src, alu_op,
                  addr_sel, mem_read, mem_write, halted, fault};

    function automatic logic [11:0] mk(input bit pi, input bit pl, input bit il,
                                        input bit al, input bit as, input logic [1:0] op,
                                        input bit ad, input bit mr, input bit mw,
                                        input bit h, input bit f);
        return {pi, pl, il, al, as, op, ad, mr, mw, h, f};
    endfunction

    // Monitor: every cycle the DUT presents its output vector; compare to queue head.
    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL outputs cycle %0d: no expected entry, actual=%b", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: actual=%b required=%b (pc_inc,pc_load,ir_load,acc_load,acc_src,alu_op[2],addr_sel,mem_read,mem_write,halted,fault)",
                             cyc, act, e);
                end
            end
        end
    end

    // Driver: inputs for this cycle are already set; push expectation, advance.
    task automatic step(input logic [11:0] ev);
        exp_q.push_back(ev);
        @(posedge clock);
        #1;
    endtask

    task automatic rnd_flags();
        acc_zero = 1'($urandom);
        acc_neg  = 1'($urandom);
    endtask

    // Terminal state: a few cycles of random inputs, then reset back to IDLE.
    task automatic terminal(input bit f);
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom);
            instr     = 8'($urandom);
            rnd_flags();
            step(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, f));
        end
        reset = 1'b1;
        step(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, f));
        reset = 1'b0;
        step(ZERO);
    endtask

    // Fetch phase: ready arrives on fetch cycle index fw; cycle index TO without ready faults.
    task automatic do_fetch(input logic [7:0] ins, input int fw, output bit faulted);
        bit rdy;
        instr   = ins;
        faulted = 1'b1;
        for (int k = 0; k <= TO; k++) begin
            rdy = (k == fw);
            mem_ready = rdy;
            rnd_flags();
            step(mk(rdy, 0, rdy, 0, 0, 2'b00, 0, 1, 0, 0, 0));
            if (rdy) begin
                faulted = 1'b0;
                break;
            end
        end
    endtask

    // One whole instruction starting in FETCH; returns with the DUT back in FETCH.
    task automatic run_instr(input logic [7:0] ins, input int fw, input int mw,
                             input bit z, input bit n);
        bit         f;
        bit         rdy;
        bit         done;
        logic [3:0] op;
        logic [1:0] aop;
        op = ins[7:4];
        do_fetch(ins, fw, f);
        if (f) begin
            terminal(1'b1);
            return;
        end
        mem_ready = 1'($urandom);
        rnd_flags();
        step(ZERO);
        if (op == 4'h0) return;
        if (op >= 4'h1 && op <= 4'h5) begin
            done = 1'b0;
            for (int k = 0; k <= TO; k++) begin
                rdy = (k == mw);
                mem_ready = rdy;
                rnd_flags();
                aop = 2'b00;
                if (rdy && op == 4'h4) aop = 2'b01;
                if (rdy && op == 4'h5) aop = 2'b10;
                step(mk(0, 0, 0, rdy && op != 4'h2, rdy && op >= 4'h3, aop,
                        1, op != 4'h2, op == 4'h2, 0, 0));
                if (rdy) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) terminal(1'b1);
            return;
        end
        if (op >= 4'h6 && op <= 4'h8) begin
            acc_zero  = z;
            acc_neg   = n;
            mem_ready = 1'($urandom);
            step(mk(0, (op == 4'h6) || (op == 4'h7 && z) || (op == 4'h8 && n),
                    0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
            return;
        end
        terminal(op != 4'hF);
    endtask

    // Reset asserted during a stalled LOAD memory cycle.
    task automatic reset_in_load();
        bit f;
        do_fetch(8'h1B, 0, f);
        if (f) begin
            terminal(1'b1);
            return;
        end
        step(ZERO);
        mem_ready = 1'b0;
        reset = 1'b1;
        step(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));
        reset = 1'b0;
        step(ZERO);
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int sel;
        logic [3:0] op;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        step(ZERO);

        run_instr(8'h35, 0, 0, 0, 0);
        run_instr(8'h7A, 0, 0, 1, 0);
        run_instr(8'h7A, 0, 0, 0, 0);
        run_instr(8'h2C, 0, 3, 0, 0);
        run_instr(8'h00, 99, 0, 0, 0);
        run_instr(8'h10, TO, TO, 0, 0);
        run_instr(8'h40, 0, 99, 0, 0);
        run_instr(8'h8E, 1, 0, 0, 1);
        run_instr(8'h57, 2, 1, 0, 0);
        run_instr(8'hF0, 0, 0, 0, 0);
        run_instr(8'h93, 0, 0, 0, 0);
        reset_in_load();

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 85)      op = 4'($urandom_range(0, 8));
            else if (sel < 92) op = 4'hF;
            else               op = 4'($urandom_range(9, 14));
            run_instr({op, 4'($urandom)},
                      ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual=%0d leftover expectations required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
